// File: rtl/axil_req_arbiter.sv
// ---------------------------------------------------------------------------
// axil_req_arbiter
//
// Shares one AXI4-Lite master port between NUM_REQ simple requesters using
// round-robin arbitration. Only one transaction is outstanding at a time; each
// accepted request ends with a single-cycle rsp_valid pulse back to the
// requester that was granted.
//
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   req_valid/_write/_addr/_wdata
//                          per-requester request (flattened vectors)
//   req_ready              one-cycle one-hot accept pulse
//   rsp_valid              one-cycle one-hot completion pulse
//   rsp_rdata, rsp_err     read data of the last read / error of last completion
//   M_AXI_*                AXI4-Lite master (AW, W, B, AR, R channels)
// ---------------------------------------------------------------------------
module axil_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,

  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,

  output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_RD_A,
    S_RD_D,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [NUM_REQ-1:0]      grantOh_q;
  logic [NUM_REQ-1:0]      reqReady_q;
  logic [NUM_REQ-1:0]      rspValid_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rspErr_q;
  logic                    awValid_q;
  logic                    wValid_q;
  logic                    bReady_q;
  logic                    arValid_q;
  logic                    rReady_q;

  logic                    anyValid;
  logic [IDX_W-1:0]        grantIdx;
  logic [IDX_W-1:0]        candIdx;
  logic [NUM_REQ-1:0]      grantOh;
  logic [ADDR_WIDTH-1:0]   selAddr;
  logic [DATA_WIDTH-1:0]   selWdata;
  logic                    selWrite;
  logic [IDX_W-1:0]        ptr_d;
  logic                    awDone;
  logic                    wDone;

  // Only the SLVERR/DECERR bit of the responses and the word-aligned part of
  // the byte address are meaningful here.
  logic                    unusedBits;
  assign unusedBits = ^{M_AXI_BRESP[0], M_AXI_RRESP[0], selAddr[1:0]};

  // Round-robin search: walk offsets from the far end down to the pointer so
  // the last hit written is the first requester at/after the pointer.
  always_comb begin
    anyValid = 1'b0;
    grantIdx = '0;
    candIdx  = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      candIdx = IDX_W'((int'(ptr_q) + off) % NUM_REQ);
      if (req_valid[candIdx]) begin
        anyValid = 1'b1;
        grantIdx = candIdx;
      end
    end
  end

  // Mux out the winning requester's fields with constant slices.
  always_comb begin
    grantOh  = '0;
    selAddr  = '0;
    selWdata = '0;
    selWrite = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantIdx == IDX_W'(i)) begin
        grantOh[i] = 1'b1;
        selAddr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        selWdata   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        selWrite   = req_write[i];
      end
    end
  end

  assign ptr_d = (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);

  // A channel counts as done once its valid has dropped or handshakes now.
  assign awDone = !awValid_q || M_AXI_AWREADY;
  assign wDone  = !wValid_q  || M_AXI_WREADY;

  // Sequencer with registered outputs. req_ready/rsp_valid default low each
  // cycle so they can only ever be single-cycle pulses.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grantOh_q  <= '0;
      reqReady_q <= '0;
      rspValid_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rspErr_q   <= 1'b0;
      awValid_q  <= 1'b0;
      wValid_q   <= 1'b0;
      bReady_q   <= 1'b0;
      arValid_q  <= 1'b0;
      rReady_q   <= 1'b0;
    end else begin
      reqReady_q <= '0;
      rspValid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (anyValid) begin
            reqReady_q <= grantOh;
            grantOh_q  <= grantOh;
            ptr_q      <= ptr_d;
            addr_q     <= {selAddr[ADDR_WIDTH-1:2], 2'b00};
            wdata_q    <= selWdata;
            if (selWrite) begin
              awValid_q <= 1'b1;
              wValid_q  <= 1'b1;
              state_q   <= S_WR;
            end else begin
              arValid_q <= 1'b1;
              state_q   <= S_RD_A;
            end
          end
        end
        S_WR: begin
          if (M_AXI_AWREADY) awValid_q <= 1'b0;
          if (M_AXI_WREADY)  wValid_q  <= 1'b0;
          if (awDone && wDone) begin
            bReady_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            bReady_q   <= 1'b0;
            rspErr_q   <= M_AXI_BRESP[1];
            rspValid_q <= grantOh_q;
            state_q    <= S_DONE;
          end
        end
        S_RD_A: begin
          if (M_AXI_ARREADY) begin
            arValid_q <= 1'b0;
            rReady_q  <= 1'b1;
            state_q   <= S_RD_D;
          end
        end
        S_RD_D: begin
          if (M_AXI_RVALID) begin
            rReady_q   <= 1'b0;
            rdata_q    <= M_AXI_RDATA;
            rspErr_q   <= M_AXI_RRESP[1];
            rspValid_q <= grantOh_q;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = reqReady_q;
  assign rsp_valid     = rspValid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = rspErr_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awValid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wValid_q;
  assign M_AXI_BREADY  = bReady_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arValid_q;
  assign M_AXI_RREADY  = rReady_q;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_req_arbiter
//
// Directed bench for axil_req_arbiter. A small behavioural AXI4-Lite slave
// with a 4-word memory and programmable ready delays / response codes sits
// on the master port. Each scenario task drives requests and compares DUT
// outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_axil_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 32;

  logic            ACLK;
  logic            ARESETN;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   M_AXI_AWADDR;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;
  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;
  logic [AW-1:0]   M_AXI_ARADDR;
  logic            M_AXI_ARVALID;
  logic            M_AXI_ARREADY;
  logic [DW-1:0]   M_AXI_RDATA;
  logic [1:0]      M_AXI_RRESP;
  logic            M_AXI_RVALID;
  logic            M_AXI_RREADY;

  int errors = 0;
  int checks = 0;

  axil_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Slave model state and configuration
  logic [DW-1:0] mem [0:3];
  int            cfgAwDelay = 0;
  int            cfgWDelay  = 0;
  int            cfgArDelay = 0;
  logic [1:0]    cfgBResp   = 2'b00;
  logic [1:0]    cfgRResp   = 2'b00;
  int            awCnt, wCnt, arCnt;
  bit            awFire, wFire, bFire, arFire, rFire, awGot, wGot, arGot;
  logic [AW-1:0] awAddrS, arAddrS;
  logic [DW-1:0] wDataS;

  // Observations gathered by run_txn
  int            monAwHigh, monWHigh, monBreadyFirst;
  bit            monAwSeen;
  logic [AW-1:0] monAwAddr;
  logic [DW-1:0] monWdata;
  logic [3:0]    monWstrb;
  logic [N-1:0]  monRspVec;
  logic [DW-1:0] monRdata;
  logic          monErr;

  // The slave works on falling edges: a ready/valid decided at one negedge
  // handshakes on the next rising edge and is retired at the negedge after.
  task automatic slave_loop();
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        awCnt = 0; wCnt = 0; arCnt = 0;
        awFire = 0; wFire = 0; bFire = 0; arFire = 0; rFire = 0;
        awGot = 0; wGot = 0; arGot = 0;
      end else begin
        if (awFire) begin awFire = 0; M_AXI_AWREADY = 1'b0; awGot = 1; end
        if (wFire)  begin wFire  = 0; M_AXI_WREADY  = 1'b0; wGot  = 1; end
        if (bFire)  begin bFire  = 0; M_AXI_BVALID  = 1'b0; end
        if (arFire) begin arFire = 0; M_AXI_ARREADY = 1'b0; arGot = 1; end
        if (rFire)  begin rFire  = 0; M_AXI_RVALID  = 1'b0; end
        if (awGot && wGot) begin
          mem[awAddrS[3:2]] = wDataS;
          M_AXI_BRESP = cfgBResp; M_AXI_BVALID = 1'b1;
          awGot = 0; wGot = 0;
        end
        if (arGot) begin
          M_AXI_RDATA = mem[arAddrS[3:2]];
          M_AXI_RRESP = cfgRResp; M_AXI_RVALID = 1'b1;
          arGot = 0;
        end
        if (M_AXI_AWVALID && !awGot) begin
          if (awCnt >= cfgAwDelay) begin
            M_AXI_AWREADY = 1'b1; awFire = 1; awAddrS = M_AXI_AWADDR; awCnt = 0;
          end else awCnt++;
        end
        if (M_AXI_WVALID && !wGot) begin
          if (wCnt >= cfgWDelay) begin
            M_AXI_WREADY = 1'b1; wFire = 1; wDataS = M_AXI_WDATA; wCnt = 0;
          end else wCnt++;
        end
        if (M_AXI_ARVALID && !arGot) begin
          if (arCnt >= cfgArDelay) begin
            M_AXI_ARREADY = 1'b1; arFire = 1; arAddrS = M_AXI_ARADDR; arCnt = 0;
          end else arCnt++;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) bFire = 1;
        if (M_AXI_RVALID && M_AXI_RREADY) rFire = 1;
      end
    end
  endtask

  // Issue one request from requester idx and follow it to its rsp_valid,
  // recording channel activity. Cycle 0 is the cycle req_ready is seen.
  task automatic run_txn(input int idx, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, output bit timedOut);
    bit got;
    bit done;
    int cyc;
    timedOut = 0; monAwHigh = 0; monWHigh = 0; monBreadyFirst = -1; monAwSeen = 0;
    monRspVec = '0; monRdata = '0; monErr = 1'b0;
    monAwAddr = '0; monWdata = '0; monWstrb = '0;
    @(negedge ACLK);
    req_write[idx] = wr;
    req_addr[idx*AW +: AW] = addr;
    req_wdata[idx*DW +: DW] = wd;
    req_valid[idx] = 1'b1;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge ACLK);
      if (req_ready[idx]) got = 1;
    end
    req_valid[idx] = 1'b0;
    if (!got) begin
      timedOut = 1;
      return;
    end
    done = 0;
    cyc = 0;
    while (!done && cyc < 200) begin
      if (M_AXI_AWVALID) begin
        monAwHigh++;
        if (!monAwSeen) begin
          monAwSeen = 1; monAwAddr = M_AXI_AWADDR; monWdata = M_AXI_WDATA; monWstrb = M_AXI_WSTRB;
        end
      end
      if (M_AXI_WVALID) monWHigh++;
      if (M_AXI_BREADY && monBreadyFirst < 0) monBreadyFirst = cyc;
      if (rsp_valid != '0) begin
        done = 1; monRspVec = rsp_valid; monRdata = rsp_rdata; monErr = rsp_err;
      end else begin
        @(negedge ACLK);
        cyc++;
      end
    end
    if (!done) timedOut = 1;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b01;
    repeat (3) @(negedge ACLK);
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready);
    end
    checks++;
    if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got valid=%b err=%b rdata=%h expected 00/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_axi: got aw=%b w=%b b=%b ar=%b r=%b expected all 0",
               M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY);
    end
    req_valid = 2'b00;
    req_write = 2'b00;
    ARESETN = 1'b1;
    @(negedge ACLK);
  endtask

  // T1: requester 0 fills the registers, requester 1 reads them back.
  task automatic test_write_read();
    bit to;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 1'b1, AW'(i * 4), DW'(i + 1), to);
      checks++;
      if (to || monRspVec !== 2'b01 || monErr !== 1'b0) begin
        errors++;
        $display("[TB] FAIL t1_write[%0d]: got timeout=%0d rsp=%b err=%b expected 0/01/0", i, to, monRspVec, monErr);
      end
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 1'b0, AW'(i * 4), '0, to);
      checks++;
      if (to || monRspVec !== 2'b10 || monRdata !== DW'(i + 1) || monErr !== 1'b0) begin
        errors++;
        $display("[TB] FAIL t1_read[%0d]: got timeout=%0d rsp=%b rdata=%h err=%b expected 0/10/%h/0",
                 i, to, monRspVec, monRdata, monErr, DW'(i + 1));
      end
    end
    @(negedge ACLK);
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++; $display("[TB] FAIL t1_rsp_one_cycle: got %b expected 00", rsp_valid);
    end
  endtask

  // T2: both requesters valid from reset release; grants alternate and the
  // DONE -> next req_ready distance is exactly two cycles (one IDLE between).
  task automatic test_round_robin();
    int expOrder [4] = '{0, 1, 0, 1};
    logic [N-1:0] expOh;
    logic [N-1:0] lastReady;
    logic [DW-1:0] expData;
    int grants, rsps, cyc, lastRspCyc;
    ARESETN = 1'b0;
    req_write = 2'b00;
    req_addr = {4'h4, 4'h0};
    req_valid = 2'b11;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    grants = 0; rsps = 0; cyc = 0; lastRspCyc = 0; lastReady = '0;
    while ((grants < 4 || rsps < 4) && cyc < 300) begin
      @(negedge ACLK);
      cyc++;
      if (req_ready != '0) begin
        expOh = 2'b01 << expOrder[grants];
        checks++;
        if (req_ready !== expOh) begin
          errors++; $display("[TB] FAIL t2_grant[%0d]: got %b expected %b", grants, req_ready, expOh);
        end
        if (grants > 0) begin
          checks++;
          if (cyc - lastRspCyc !== 2) begin
            errors++; $display("[TB] FAIL t2_gap[%0d]: got %0d cycles expected 2", grants, cyc - lastRspCyc);
          end
        end
        lastReady = req_ready;
        grants++;
        if (grants == 4) req_valid = 2'b00;
      end
      if (rsp_valid != '0) begin
        expData = (expOrder[rsps] == 0) ? 32'd1 : 32'd2;
        checks++;
        if (rsp_valid !== lastReady || rsp_rdata !== expData) begin
          errors++;
          $display("[TB] FAIL t2_rsp[%0d]: got valid=%b rdata=%h expected %b/%h", rsps, rsp_valid, rsp_rdata, lastReady, expData);
        end
        lastRspCyc = cyc;
        rsps++;
      end
    end
    checks++;
    if (grants != 4 || rsps != 4) begin
      errors++; $display("[TB] FAIL t2_timeout: got grants=%0d rsps=%0d expected 4/4", grants, rsps);
    end
    req_valid = 2'b00;
  endtask

  // T3: AWREADY three cycles late, WREADY immediate.
  task automatic test_aw_delay();
    bit to;
    cfgAwDelay = 3;
    run_txn(0, 1'b1, 4'h8, 32'h33, to);
    cfgAwDelay = 0;
    checks++;
    if (to) begin errors++; $display("[TB] FAIL t3_timeout: got timeout expected completion"); end
    checks++;
    if (monAwHigh != 4) begin errors++; $display("[TB] FAIL t3_awvalid_len: got %0d expected 4", monAwHigh); end
    checks++;
    if (monWHigh != 1) begin errors++; $display("[TB] FAIL t3_wvalid_len: got %0d expected 1", monWHigh); end
    checks++;
    if (monBreadyFirst != 4) begin errors++; $display("[TB] FAIL t3_bready_cycle: got %0d expected 4", monBreadyFirst); end
  endtask

  // T4: error responses complete normally; rsp_rdata survives writes.
  task automatic test_error_resp();
    bit to;
    cfgRResp = 2'b10;
    run_txn(1, 1'b0, 4'h0, '0, to);
    cfgRResp = 2'b00;
    checks++;
    if (to || monRspVec !== 2'b10 || monErr !== 1'b1 || monRdata !== 32'd1) begin
      errors++;
      $display("[TB] FAIL t4_rd_err: got timeout=%0d rsp=%b err=%b rdata=%h expected 0/10/1/1", to, monRspVec, monErr, monRdata);
    end
    run_txn(0, 1'b0, 4'h4, '0, to);
    checks++;
    if (to || monRspVec !== 2'b01 || monErr !== 1'b0 || monRdata !== 32'd2) begin
      errors++;
      $display("[TB] FAIL t4_next_rd: got timeout=%0d rsp=%b err=%b rdata=%h expected 0/01/0/2", to, monRspVec, monErr, monRdata);
    end
    cfgBResp = 2'b11;
    run_txn(1, 1'b1, 4'hC, 32'd4, to);
    cfgBResp = 2'b00;
    checks++;
    if (to || monRspVec !== 2'b10 || monErr !== 1'b1 || monRdata !== 32'd2) begin
      errors++;
      $display("[TB] FAIL t4_wr_err: got timeout=%0d rsp=%b err=%b rdata=%h expected 0/10/1/2", to, monRspVec, monErr, monRdata);
    end
  endtask

  // T6: unaligned byte address is word-aligned on the bus.
  task automatic test_addr_align();
    bit to;
    run_txn(0, 1'b1, 4'h6, 32'hA5, to);
    checks++;
    if (to || monAwAddr !== 4'h4 || monWstrb !== 4'hF || monWdata !== 32'hA5) begin
      errors++;
      $display("[TB] FAIL t6_aw: got timeout=%0d addr=%h strb=%h wdata=%h expected 0/4/F/A5", to, monAwAddr, monWstrb, monWdata);
    end
    run_txn(1, 1'b0, 4'h4, '0, to);
    checks++;
    if (to || monRdata !== 32'hA5) begin
      errors++; $display("[TB] FAIL t6_readback: got timeout=%0d rdata=%h expected 0/A5", to, monRdata);
    end
  endtask

  // T5: reset while ARVALID waits; then requester 1 withdraws before ready.
  task automatic test_reset_abort();
    bit got;
    bit sawRsp;
    bit done;
    cfgArDelay = 100;
    @(negedge ACLK);
    req_write = 2'b00;
    req_addr = {4'h0, 4'h0};
    req_valid = 2'b01;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge ACLK);
      if (req_ready[0]) got = 1;
    end
    req_valid = 2'b00;
    @(negedge ACLK);
    checks++;
    if (!got || M_AXI_ARVALID !== 1'b1) begin
      errors++; $display("[TB] FAIL t5_arvalid_wait: got ready=%0d arvalid=%b expected 1/1", got, M_AXI_ARVALID);
    end
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if (M_AXI_ARVALID !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++; $display("[TB] FAIL t5_async_drop: got arvalid=%b rsp=%b expected 0/00", M_AXI_ARVALID, rsp_valid);
    end
    repeat (2) @(negedge ACLK);
    cfgArDelay = 0;
    ARESETN = 1'b1;
    req_valid = 2'b11;
    got = 0;
    sawRsp = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge ACLK);
      if (rsp_valid != '0) sawRsp = 1;
      if (req_ready != '0) got = 1;
    end
    req_valid = 2'b00;
    checks++;
    if (!got || req_ready !== 2'b01) begin
      errors++; $display("[TB] FAIL t5_first_grant: got seen=%0d ready=%b expected 1/01", got, req_ready);
    end
    checks++;
    if (sawRsp) begin errors++; $display("[TB] FAIL t5_no_rsp: got rsp before grant expected none"); end
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge ACLK);
      if (rsp_valid != '0) done = 1;
    end
    checks++;
    if (!done || rsp_valid !== 2'b01) begin
      errors++; $display("[TB] FAIL t5_rsp: got seen=%0d rsp=%b expected 1/01", done, rsp_valid);
    end
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge ACLK);
      if (req_ready != '0) got = 1;
    end
    checks++;
    if (got) begin errors++; $display("[TB] FAIL t5_withdraw: got grant for withdrawn request expected none"); end
  endtask

  initial begin
    ARESETN = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    fork
      slave_loop();
    join_none
    $display("[TB] starting");
    test_reset();
    test_write_read();
    test_round_robin();
    test_aw_delay();
    test_error_resp();
    test_addr_align();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
